// File: rtl/dffram_wb_slave.sv
// Wishbone classic slave front-end driving a single-port DFFRAM macro.
// Optional range/byte-select checker enabled by defining DFFRAM_WB_ERR_EN.
module dffram_wb_slave #(
  parameter int COLS    = 1,
  parameter int A_WIDTH = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [31:0]        ram_di,
  output logic [A_WIDTH-1:0] ram_a,
  input  logic [31:0]        ram_do
);

  typedef enum logic [1:0] {
    IDLE,
    ACK
`ifdef DFFRAM_WB_ERR_EN
    , ERR
`endif
  } state_e;

  state_e state_q, state_d;
  logic   rd_q, rd_d;
  logic   req;
  logic   legal;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef DFFRAM_WB_ERR_EN
  logic err_c;
  assign legal    = ((wb_adr_i >> A_WIDTH) == '0) && (wb_sel_i != 4'b0000);
  assign wb_err_o = err_c;
`else
  logic unused_adr_hi;
  assign legal         = 1'b1;
  assign unused_adr_hi = ^wb_adr_i[31:A_WIDTH];
  assign wb_err_o      = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  // Outputs are gated by RSTn so a master still requesting during reset
  // cannot reach the RAM through the combinational IDLE path.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_a    = '0;
    ram_di   = '0;
    wb_ack_o = 1'b0;
    wb_dat_o = '0;
`ifdef DFFRAM_WB_ERR_EN
    err_c    = 1'b0;
`endif
    if (RSTn) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (legal) begin
              ram_en  = 1'b1;
              ram_a   = wb_adr_i[A_WIDTH-1:0];
              ram_di  = wb_dat_i;
              ram_we  = wb_we_i ? wb_sel_i : 4'b0000;
              rd_d    = ~wb_we_i;
              state_d = ACK;
            end
`ifdef DFFRAM_WB_ERR_EN
            else begin
              state_d = ERR;
            end
`endif
          end
        end
        ACK: begin
          wb_ack_o = req;
          if (rd_q) wb_dat_o = ram_do;
          state_d  = IDLE;
        end
`ifdef DFFRAM_WB_ERR_EN
        ERR: begin
          err_c   = req;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_wb_slave.sv
// Scoreboard bench for dffram_wb_slave with a behavioural DFFRAM model.
module tb_dffram_wb_slave;

  localparam int COLS    = 1;
  localparam int A_WIDTH = 8;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic               wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]         wb_sel_i;
  logic [31:0]        wb_adr_i, wb_dat_i, wb_dat_o;
  logic               wb_ack_o, wb_err_o;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [31:0]        ram_di;
  logic [A_WIDTH-1:0] ram_a;
  logic [31:0]        ram_do;

  dffram_wb_slave #(.COLS(COLS), .A_WIDTH(A_WIDTH)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ram_en(ram_en), .ram_we(ram_we), .ram_di(ram_di), .ram_a(ram_a),
    .ram_do(ram_do)
  );

  always #5 CLK = ~CLK;

  // RAM model: registered Do, cleared on any edge with EN=0
  logic [31:0] mem [0:(256*COLS)-1];
  initial begin
    for (int i = 0; i < 256*COLS; i++) mem[i] = '0;
    ram_do = '0;
  end
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= mem[ram_a[A_WIDTH-1:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a[A_WIDTH-1:2]][b*8 +: 8] <= ram_di[b*8 +: 8];
    end else begin
      ram_do <= '0;
    end
  end

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   en_cnt = 0;
  int   ack_cnt = 0;
  int   err_cnt = 0;

  always @(posedge CLK) cyc_cnt++;

  // Monitor: every termination must match the oldest expectation
  always @(negedge CLK) begin
    if (RSTn) begin
      if (ram_en) en_cnt++;
      if (wb_ack_o) ack_cnt++;
      if (wb_err_o) err_cnt++;
      if (wb_ack_o || wb_err_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_term ack=%0b err=%0b cyc=%0d", wb_ack_o, wb_err_o, cyc_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (wb_err_o !== e.is_err || wb_ack_o !== !e.is_err ||
              wb_dat_o !== e.dat || cyc_cnt != e.cyc) begin
            errors++;
            $display("FAIL term actual err=%0b ack=%0b dat=%h cyc=%0d required err=%0b dat=%h cyc=%0d",
                     wb_err_o, wb_ack_o, wb_dat_o, cyc_cnt, e.is_err, e.dat, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = '0;   wb_adr_i = '0;   wb_dat_i = '0;
  endtask

  task automatic drive(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_sel_i = sel;  wb_adr_i = adr;  wb_dat_i = dat;
  endtask

  // Request in cycle N, termination expected in N+1, strobe dropped after N+1
  task automatic txn(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                     input logic [31:0] dat, input bit exp_err, input logic [31:0] exp_dat);
    @(posedge CLK); #1;
    sb.push_back('{exp_err, exp_dat, cyc_cnt + 1});
    drive(we, sel, adr, dat);
    @(posedge CLK);
    @(posedge CLK); #1;
    idle();
  endtask

  int en0, ack0, c;

  initial begin
    RSTn = 1'b0;
    idle();
    #2;
    drive(1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    check("rst_ack", {31'b0, wb_ack_o}, 32'h0);
    check("rst_en", {31'b0, ram_en}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_err", {31'b0, wb_err_o}, 32'h0);
    idle();
    @(negedge CLK); @(negedge CLK);
    RSTn = 1'b1;

    // Write then read
    en0 = en_cnt;
    txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    check("wr_en_pulses", en_cnt - en0, 1);
    en0 = en_cnt;
    txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    check("rd_en_pulses", en_cnt - en0, 1);
    @(negedge CLK);
    check("rd_dat_cleared", wb_dat_o, 32'h0);

    // Byte lane 1 only
    txn(1'b1, 4'h2, 32'h10, 32'h11223344, 1'b0, 32'h0);
    txn(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEAD33EF);

    // Held strobe for 6 cycles: accesses in c, c+2, c+4
    en0 = en_cnt; ack0 = ack_cnt;
    @(posedge CLK); #1;
    c = cyc_cnt;
    for (int k = 0; k < 3; k++) sb.push_back('{1'b0, 32'hDEAD33EF, c + 1 + 2*k});
    drive(1'b0, 4'hF, 32'h10, 32'h0);
    repeat (6) @(posedge CLK);
    #1 idle();
    check("held_en_pulses", en_cnt - en0, 3);
    check("held_acks", ack_cnt - ack0, 3);

    // Abort: cyc dropped in N+1, write still lands
    ack0 = ack_cnt;
    @(posedge CLK); #1;
    drive(1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
    @(posedge CLK); #1;
    idle();
    @(posedge CLK); #1;
    check("abort_no_ack", ack_cnt - ack0, 0);
    txn(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D);

    // Out-of-range address and empty byte select
    txn(1'b1, 4'hF, 32'h0, 32'h12345678, 1'b0, 32'h0);
    en0 = en_cnt;
`ifdef DFFRAM_WB_ERR_EN
    txn(1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 32'h0);
    txn(1'b1, 4'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0);
    check("illegal_no_en", en_cnt - en0, 0);
`else
    txn(1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'h12345678);
    txn(1'b1, 4'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
    check("alias_en", en_cnt - en0, 2);
`endif
    txn(1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h12345678);

    // Reset asserted mid-ACK while the master keeps requesting
    @(posedge CLK); #1;
    drive(1'b1, 4'hF, 32'h30, 32'hA5A5A5A5);
    @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    check("midrst_ack", {31'b0, wb_ack_o}, 32'h0);
    check("midrst_en", {31'b0, ram_en}, 32'h0);
    check("midrst_a", {{(32-A_WIDTH){1'b0}}, ram_a}, 32'h0);
    check("midrst_we", {28'b0, ram_we}, 32'h0);
    @(posedge CLK); #1;
    check("midrst_en_held", {31'b0, ram_en}, 32'h0);
    idle();
    @(negedge CLK);
    RSTn = 1'b1;
    txn(1'b0, 4'hF, 32'h30, 32'h0, 1'b0, 32'hA5A5A5A5);

    repeat (3) @(posedge CLK);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
